ifetch: RTL and testbench
=========================

# ifetch

Instruction fetch stage directly upstream of the instruction stream buffer. Issues line reads (four 16-bit instructions per 64-bit line) to instruction memory, latches each returned line, and serializes it into the buffer one instruction per cycle over the buffer's push handshake. Handles branch redirects, including discarding an in-flight memory response, and honours the pipeline pause.

## Interface
- `ADDR_W`, default 16: instruction address width, in instruction (16-bit) units.
- `INSN_W`, default 16: instruction width.
- `RESET_PC`, default 16'h0000: fetch address after reset.
- `clk` in 1: the single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `memReqValid` out 1: line read request valid.
- `memReqAddr` out ADDR_W: line address; low 2 bits are always 0.
- `memReqReady` in 1: memory accepts the request.
- `memRespValid` in 1: line data valid, for one cycle per accepted request.
- `memRespData` in 64: line data; slot i is bits [16i+15:16i].
- `inReady` in 1: buffer can accept a push.
- `inEnable` out 1: push strobe to the buffer.
- `dataOut` out INSN_W: instruction being pushed.
- `pcOut` out ADDR_W: address of `dataOut`.
- `pause` in 1: pipeline pause; no push while high.
- `redirectValid` in 1: branch redirect.
- `redirectPc` in ADDR_W: redirect target; any alignment is allowed.

## Operation
- States: REQ, WAIT, DISCARD, DRAIN.
- Registers:
  - `pc` (ADDR_W): next instruction to push.
  - `line` (64 bits): latched line.
  - `redirPending`: records that a redirect hit an in-flight request.
- **REQ**
  - `memReqValid` = 1 and `memReqAddr` = {pc[ADDR_W-1:2], 2'b00}.
  - On `memReqReady`, go to WAIT.
  - The request stays asserted and the address stays stable until it is accepted.
- **WAIT**
  - On `memRespValid`, latch `memRespData` into `line` and go to DRAIN.
- **DRAIN**
  - Slot index is `pc[1:0]`. `dataOut` = slot pc[1:0] of `line`; `pcOut` = `pc`.
  - `inEnable` = `inReady` & !`pause` & !`redirectValid` (combinational).
  - On each push, `pc` increments. When the pushed slot is 3, go to REQ.
- **Redirect (priority over every other transition)**
  - `pc` is loaded from `redirectPc`.
  - From REQ or DRAIN: go to REQ.
  - From WAIT: go to DISCARD.
  - If the request is accepted in the same cycle as the redirect while in REQ, go to DISCARD.
- **DISCARD**
  - Wait for the stale `memRespValid`, drop its data, then go to REQ.
  - A further redirect while in DISCARD only reloads `pc`.
- A misaligned redirect target pushes only slots pc[1:0]..3 of the first line.
- `pc` wraps from all-ones to 0 modulo 2^ADDR_W; the line address wraps the same way.
- At most one outstanding memory request at any time.
- **Reset**
  - `pc` = `RESET_PC`, state REQ, `line` = 0.
  - `memReqValid` = 0, `inEnable` = 0, `dataOut` = 0, `pcOut` = 0 while `reset` is high.
  - Reset mid-transaction: any response still outstanding after reset deasserts must be ignored. `redirPending` is set on reset if the state was WAIT; in that case enter DISCARD instead of REQ.

## Timing
- Request is issued in the first cycle after `reset` deasserts.
- Response is accepted no earlier than the cycle after request acceptance.
- First push occurs in the cycle after `memRespValid`.
- Steady state with a 1-cycle memory: 4 pushes, then 2 bubble cycles (REQ, WAIT).
- Push handshake: one instruction transfers per cycle in which `inEnable` is 1. `inEnable` is never high while `inReady` is 0.
- `pause` or `!inReady` holds DRAIN with `dataOut`/`pcOut` stable.
- A redirect takes effect on the next edge. No instruction from the old path is pushed in or after the redirect cycle.

## Structure
- Shared package `ifetch_pkg`:
  - state enum (REQ, WAIT, DISCARD, DRAIN)
  - `LINE_INSNS`=4
  - `LINE_W`=64
  - `RESET_PC`
- Single module; no sub-module is needed. Slot select and pc arithmetic stay inline.

## Test plan
- **Reset and first line:** reset 2 cycles, then memory returns 64'h0004_0003_0002_0001 one cycle after accept. Pushes are 0001, 0002, 0003, 0004 with pcOut 0..3, then a request at addr 4.
- **Backpressure:** `inReady`=0 for 3 cycles mid-line, then `pause`=1 for 2 cycles. `inEnable` stays 0 and `dataOut` is held; there are no lost or duplicate pushes.
- **Redirect in WAIT:** redirect to 16'h0042 while waiting. The stale response is dropped, the next request is at addr 16'h0040, and pushes are slots 2 and 3 only with pcOut 0042, 0043.
- **Redirect during DRAIN with `inReady`=1:** no push occurs in that cycle, and the next request goes to the target line.
- **Wrap:** RESET_PC=16'hFFFC. Pushes have pcOut FFFC..FFFF, and the next `memReqAddr` is 16'h0000.
- **Reset mid-WAIT:** the response arrives 2 cycles after reset deasserts. It is discarded, and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package ifetch_pkg;

    typedef enum logic [1:0] {
        REQ     = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2,
        DRAIN   = 2'd3
    } stateT;

    localparam int          LINE_INSNS = 4;
    localparam int          LINE_W     = 64;
    localparam logic [15:0] RESET_PC   = 16'h0000;

endpackage

// File: rtl/ifetch.sv
// Instruction fetch: requests 64-bit lines from instruction memory and feeds the
// stream buffer one instruction per cycle, following branch redirects.
module ifetch
    import ifetch_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter int                INSN_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(ifetch_pkg::RESET_PC)
) (
    input  logic              clk,
    input  logic              reset,
    output logic              memReqValid,
    output logic [ADDR_W-1:0] memReqAddr,
    input  logic              memReqReady,
    input  logic              memRespValid,
    input  logic [LINE_W-1:0] memRespData,
    input  logic              inReady,
    output logic              inEnable,
    output logic [INSN_W-1:0] dataOut,
    output logic [ADDR_W-1:0] pcOut,
    input  logic              pause,
    input  logic              redirectValid,
    input  logic [ADDR_W-1:0] redirectPc,
    output logic [1:0]        dbgState
);

    // Handshakes: a memory request transfers on memReqValid & memReqReady and
    // holds address until then; a push transfers on every cycle inEnable is 1,
    // which is only ever raised while inReady is 1.

    localparam int SLOT_W = LINE_W / LINE_INSNS;

    stateT             state, stateNext;
    logic [ADDR_W-1:0] pc, pcNext;
    logic [LINE_W-1:0] line;
    logic              redirPending, redirPendingNext;
    logic              respOutstanding;
    logic              lastSlot;

    assign respOutstanding = (state == WAIT) || (state == DISCARD);
    assign lastSlot        = (pc[1:0] == 2'(LINE_INSNS - 1));

    assign memReqAddr = {pc[ADDR_W-1:2], 2'b00};
    assign dataOut    = reset ? '0 : line[pc[1:0]*SLOT_W +: INSN_W];
    assign pcOut      = reset ? '0 : pc;
    assign dbgState   = state;

    always_comb begin
        stateNext        = state;
        pcNext           = pc;
        redirPendingNext = redirPending;
        memReqValid      = 1'b0;
        inEnable         = 1'b0;

        case (state)
            REQ: begin
                memReqValid = 1'b1;
                if (memReqReady) stateNext = WAIT;
            end
            WAIT: begin
                if (memRespValid) stateNext = DRAIN;
            end
            DISCARD: begin
                if (memRespValid) begin
                    stateNext        = REQ;
                    redirPendingNext = 1'b0;
                end
            end
            DRAIN: begin
                inEnable = inReady && !pause && !redirectValid;
                if (inEnable) begin
                    pcNext = pc + ADDR_W'(1);
                    if (lastSlot) stateNext = REQ;
                end
            end
            default: stateNext = REQ;
        endcase

        if (redirectValid) begin
            pcNext = redirectPc;
            case (state)
                REQ: begin
                    stateNext        = memReqReady ? DISCARD : REQ;
                    redirPendingNext = memReqReady;
                end
                // A response landing in the redirect cycle is already gone, so
                // there is nothing left to discard.
                WAIT: begin
                    stateNext        = memRespValid ? REQ : DISCARD;
                    redirPendingNext = !memRespValid;
                end
                DRAIN:   stateNext = REQ;
                default: ;
            endcase
        end

        if (reset) begin
            memReqValid = 1'b0;
            inEnable    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // A response still owed to a pre-reset request must be swallowed.
            redirPending <= respOutstanding && !memRespValid;
            state        <= (respOutstanding && !memRespValid) ? DISCARD : REQ;
            pc           <= RESET_PC;
            line         <= '0;
        end else begin
            state        <= stateNext;
            pc           <= pcNext;
            redirPending <= redirPendingNext;
            if (state == WAIT && memRespValid && !redirectValid) line <= memRespData;
        end
    end

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: memory responder, instruction-stream scoreboard and
// directed plus randomized fetch scenarios.
module tb_ifetch;
    import ifetch_pkg::*;

    localparam logic [15:0] TB_RESET_PC = 16'hFFFC;

    logic        clk           = 1'b0;
    logic        reset         = 1'b1;
    logic        memReqValid;
    logic [15:0] memReqAddr;
    logic        memReqReady   = 1'b0;
    logic        memRespValid  = 1'b0;
    logic [63:0] memRespData   = '0;
    logic        inReady       = 1'b1;
    logic        inEnable;
    logic [15:0] dataOut;
    logic [15:0] pcOut;
    logic        pause         = 1'b0;
    logic        redirectValid = 1'b0;
    logic [15:0] redirectPc    = '0;
    logic [1:0]  dbgState;

    ifetch #(.ADDR_W(16), .INSN_W(16), .RESET_PC(TB_RESET_PC)) dut (
        .clk          (clk),
        .reset        (reset),
        .memReqValid  (memReqValid),
        .memReqAddr   (memReqAddr),
        .memReqReady  (memReqReady),
        .memRespValid (memRespValid),
        .memRespData  (memRespData),
        .inReady      (inReady),
        .inEnable     (inEnable),
        .dataOut      (dataOut),
        .pcOut        (pcOut),
        .pause        (pause),
        .redirectValid(redirectValid),
        .redirectPc   (redirectPc),
        .dbgState     (dbgState)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Instruction memory contents: word at address a.
    function automatic logic [15:0] insnAt(input logic [15:0] a);
        return (a + 16'd1) ^ {a[9:2], 8'h00};
    endfunction

    function automatic logic [63:0] lineOf(input logic [15:0] a);
        return {insnAt(a + 16'd3), insnAt(a + 16'd2), insnAt(a + 16'd1), insnAt(a)};
    endfunction

    // ---------------- scoreboard ----------------
    // Expected stream: consecutive addresses from the current path start.
    logic [31:0] exp_q[$];
    logic [15:0] fillPc;

    function automatic void topUp();
        while (exp_q.size() < 32) begin
            exp_q.push_back({fillPc, insnAt(fillPc)});
            fillPc = fillPc + 16'd1;
        end
    endfunction

    function automatic void startPath(input logic [15:0] p);
        exp_q.delete();
        fillPc = p;
        topUp();
    endfunction

    int          pushCount    = 0;
    int          firstPushCyc = 0;
    int          t0           = 0;
    int          t4           = 0;
    logic        prevHold     = 1'b0;
    logic [15:0] prevPc, prevData;

    always @(negedge clk) begin
        logic [31:0] e;
        if (reset) begin
            check("rst_memReqValid", memReqValid, 1'b0);
            check("rst_inEnable", inEnable, 1'b0);
            check("rst_dataOut", dataOut, 16'h0);
            check("rst_pcOut", pcOut, 16'h0);
            prevHold = 1'b0;
        end else begin
            if (inEnable) begin
                check("push_ready", inReady, 1'b1);
                check("push_pause", pause, 1'b0);
                check("push_redirect", redirectValid, 1'b0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL push_unexpected: got pc %0h expected no push", pcOut);
                end else begin
                    e = exp_q.pop_front();
                    check("push_pc", pcOut, e[31:16]);
                    check("push_data", dataOut, e[15:0]);
                    topUp();
                end
                if (pushCount == 0) firstPushCyc = cyc;
                pushCount++;
                if (pcOut == 16'h0000) t0 = cyc;
                if (pcOut == 16'h0004) t4 = cyc;
            end
            if (prevHold && dbgState == DRAIN) begin
                check("hold_pc", pcOut, prevPc);
                check("hold_data", dataOut, prevData);
            end
            prevHold = (dbgState == DRAIN) && !inEnable && !redirectValid;
            prevPc   = pcOut;
            prevData = dataOut;
        end
    end

    // ---------------- memory responder ----------------
    int          memLat    = 1;
    bit          randMode  = 1'b0;
    logic [15:0] reqLog[$];

    function automatic logic [15:0] logAt(input int i);
        if (i < reqLog.size()) return reqLog[i];
        return 16'hBAD1;
    endfunction

    initial begin
        logic        acc, outstanding;
        logic [15:0] accAddr, respAddr;
        int          waitCnt;
        outstanding = 1'b0;
        respAddr    = '0;
        waitCnt     = 0;
        forever begin
            @(negedge clk);
            acc     = memReqValid && memReqReady && !reset;
            accAddr = memReqAddr;
            if (memReqValid && !reset) check("req_align", memReqAddr[1:0], 2'b00);
            if (acc) begin
                check("one_outstanding", outstanding, 1'b0);
                reqLog.push_back(accAddr);
            end
            @(posedge clk);
            #1;
            memRespValid = 1'b0;
            if (acc) begin
                outstanding = 1'b1;
                respAddr    = accAddr;
                waitCnt     = (randMode ? $urandom_range(1, 3) : memLat) - 1;
            end else if (outstanding && waitCnt > 0) begin
                waitCnt--;
            end
            if (outstanding && waitCnt == 0) begin
                memRespValid = 1'b1;
                memRespData  = lineOf(respAddr);
                outstanding  = 1'b0;
            end
            memReqReady = randMode ? ($urandom_range(0, 9) < 7) : 1'b1;
        end
    end

    // ---------------- driver tasks ----------------
    int rstCyc = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic half();
        @(negedge clk);
        #1;
    endtask

    task automatic doReset(input int n);
        reset = 1'b1;
        startPath(TB_RESET_PC);
        pushCount = 0;
        repeat (n) step();
        reset  = 1'b0;
        rstCyc = cyc;
    endtask

    task automatic redirect(input logic [15:0] target);
        redirectValid = 1'b1;
        redirectPc    = target;
        startPath(target);
    endtask

    task automatic waitPushes(input string name, input int target);
        int n = 0;
        while (pushCount < target && n < 80) begin
            half();
            n++;
        end
        check(name, pushCount >= target, 1'b1);
    endtask

    task automatic waitState(input string name, input logic [1:0] st, input logic [1:0] slot,
                             input bit needPush);
        int n = 0;
        do begin
            half();
            n++;
        end while (!(dbgState == st && (!needPush || (inEnable && pcOut[1:0] == slot))) && n < 80);
        check(name, dbgState, st);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int pb, rl;

        // Reset, first line at FFFC, wrap to line 0, request at 4.
        doReset(2);
        half();
        check("boot_req_valid", memReqValid, 1'b1);
        check("boot_req_addr", memReqAddr, TB_RESET_PC);
        check("boot_state", dbgState, REQ);
        waitPushes("boot_pushes", 9);
        check("first_push_latency", firstPushCyc - rstCyc, 2);
        check("steady_bubbles", t4 - t0, 6);
        check("req0_addr", logAt(0), 16'hFFFC);
        check("req1_wrap_addr", logAt(1), 16'h0000);
        check("req2_addr", logAt(2), 16'h0004);

        // Backpressure mid-line: 3 cycles !inReady, then 2 cycles pause.
        waitState("bp_sync", DRAIN, 2'd1, 1'b1);
        step();
        pb      = pushCount;
        inReady = 1'b0;
        step();
        step();
        step();
        inReady = 1'b1;
        pause   = 1'b1;
        step();
        step();
        pause = 1'b0;
        check("stall_no_push", pushCount, pb);
        waitPushes("stall_resume", pb + 4);

        // Redirect while waiting on memory.
        memLat = 3;
        waitState("rw_sync", WAIT, 2'd0, 1'b0);
        step();
        rl = reqLog.size();
        pb = pushCount;
        redirect(16'h0042);
        step();
        redirectValid = 1'b0;
        waitPushes("rw_pushes", pb + 3);
        check("rw_req_addr", logAt(rl), 16'h0040);
        check("rw_next_req_addr", logAt(rl + 1), 16'h0044);

        // Redirect during DRAIN with inReady high, misaligned target.
        memLat = 1;
        waitState("rd_sync", DRAIN, 2'd0, 1'b1);
        step();
        rl = reqLog.size();
        pb = pushCount;
        redirect(16'h1235);
        step();
        redirectValid = 1'b0;
        check("rd_no_push", pushCount, pb);
        waitPushes("rd_pushes", pb + 3);
        check("rd_req_addr", logAt(rl), 16'h1234);

        // Reset while a request is outstanding; stale line arrives after reset.
        memLat = 6;
        waitState("rstw_sync", WAIT, 2'd0, 1'b0);
        step();
        rl = reqLog.size();
        doReset(2);
        half();
        check("rstw_state", dbgState, DISCARD);
        check("rstw_no_req", memReqValid, 1'b0);
        memLat = 1;
        waitPushes("rstw_pushes", 4);
        check("rstw_req_addr", logAt(rl), TB_RESET_PC);

        // Randomized traffic.
        randMode = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            step();
            inReady = ($urandom_range(0, 9) < 8);
            pause   = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 39) == 0) redirect(16'($urandom_range(0, 65535)));
            else redirectValid = 1'b0;
        end
        step();
        inReady       = 1'b1;
        pause         = 1'b0;
        redirectValid = 1'b0;
        pb            = pushCount;
        repeat (40) step();
        check("final_progress", pushCount > pb, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
